fp_normalizer: RTL and testbench

- Post-add normalization stage of the floating-point adder; sits directly downstream of the sign-magnitude fraction ALU.
- Takes the ALU's N-bit magnitude result, carry, zero flag and result sign, plus the pre-aligned exponent from the alignment stage.
- Iteratively shifts the fraction until the hidden bit is at position N-1, adjusting the exponent one step per cycle.
- Emits a packed sign/exponent/fraction with overflow and underflow flags; valid/ready handshake on both sides.

---
 rtl/fp_normalizer_pkg.sv | 21 ++
 rtl/fp_normalizer_norm_step.sv | 32 +++
 rtl/fp_normalizer.sv | 113 +++++++++++
 tb/tb_fp_normalizer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_normalizer_pkg.sv
// Shared types and widths for the floating-point adder normalization path.
// Fraction width includes the hidden bit; all-ones exponent encodes overflow.
package fp_pkg;

    localparam int N       = 24;
    localparam int E       = 8;
    localparam int EXP_MAX = (1 << E) - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } norm_state_t;

    typedef struct packed {
        logic           sign;
        logic [E-1:0]   exp;
        logic [N-2:0]   frac;
    } fp_word_t;

endpackage

// File: rtl/fp_normalizer_norm_step.sv
// One normalization step: shift left by one and decrement, or stop.
// Purely combinational; stop when the hidden bit is set or the exponent bottoms out.
module norm_step
    import fp_pkg::*;
(
    input  logic [N-1:0] frac_i,
    input  logic [E:0]   exp_i,
    output logic [N-1:0] frac_d,
    output logic [E:0]   exp_d,
    output logic         done_o,
    output logic         underflow_o
);

    always_comb begin
        frac_d      = frac_i;
        exp_d       = exp_i;
        done_o      = 1'b0;
        underflow_o = 1'b0;
        if (frac_i[N-1]) begin
            done_o = 1'b1;
        end else if (exp_i <= (E+1)'(1)) begin
            // Exponent cannot go lower: leave the fraction denormal.
            exp_d       = '0;
            done_o      = 1'b1;
            underflow_o = 1'b1;
        end else begin
            frac_d = {frac_i[N-2:0], 1'b0};
            exp_d  = exp_i - (E+1)'(1);
        end
    end

endmodule

// File: rtl/fp_normalizer.sv
// Post-add normalizer: one operation in flight, one shift per cycle (OutValid at T+2+k).
// InReady only in IDLE; result holds in DONE until OutReady.
module fp_normalizer
    import fp_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         InValid,
    output logic         InReady,
    input  logic [N-1:0] Frac,
    input  logic         Carry,
    input  logic         Zero,
    input  logic         Sign,
    input  logic [E-1:0] Exp,
    output logic         OutValid,
    input  logic         OutReady,
    output logic         NormSign,
    output logic [E-1:0] NormExp,
    output logic [N-2:0] NormFrac,
    output logic         Overflow,
    output logic         Underflow
);

    norm_state_t  state_q;
    logic         sign_q;
    logic [E:0]   exp_q;
    logic [N-1:0] frac_q;
    logic         ovf_q;
    logic         unf_q;

    logic [N-1:0] frac_d;
    logic [E:0]   exp_d;
    logic         step_done;
    logic         step_unf;
    fp_word_t     word;

    norm_step u_step (
        .frac_i      (frac_q),
        .exp_i       (exp_q),
        .frac_d      (frac_d),
        .exp_d       (exp_d),
        .done_o      (step_done),
        .underflow_o (step_unf)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            frac_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (InValid) begin
                        ovf_q <= 1'b0;
                        unf_q <= 1'b0;
                        if (Zero) begin
                            sign_q  <= 1'b0;
                            exp_q   <= '0;
                            frac_q  <= '0;
                            state_q <= DONE;
                        end else if (Carry && (Exp == E'(EXP_MAX - 1))) begin
                            // Wrap is checked on the incoming exponent, before the increment.
                            sign_q  <= Sign;
                            exp_q   <= (E+1)'(EXP_MAX);
                            frac_q  <= '0;
                            ovf_q   <= 1'b1;
                            state_q <= DONE;
                        end else if (Carry) begin
                            sign_q  <= Sign;
                            exp_q   <= {1'b0, Exp} + (E+1)'(1);
                            frac_q  <= {Carry, Frac[N-1:1]};
                            state_q <= NORM;
                        end else begin
                            sign_q  <= Sign;
                            exp_q   <= {1'b0, Exp};
                            frac_q  <= Frac;
                            state_q <= NORM;
                        end
                    end
                end
                NORM: begin
                    frac_q <= frac_d;
                    exp_q  <= exp_d;
                    if (step_done) begin
                        unf_q   <= step_unf;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (OutReady) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign word = '{sign: sign_q, exp: exp_q[E-1:0], frac: frac_q[N-2:0]};

    assign InReady   = (state_q == IDLE);
    assign OutValid  = (state_q == DONE);
    assign NormSign  = word.sign;
    assign NormExp   = word.exp;
    assign NormFrac  = word.frac;
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;

endmodule

// File: tb/tb_fp_normalizer.sv
// Directed bench for fp_normalizer: hand-computed latencies and packed results.
module tb_fp_normalizer;
    import fp_pkg::*;

    logic         clock;
    logic         reset;
    logic         InValid;
    logic         InReady;
    logic [N-1:0] Frac;
    logic         Carry;
    logic         Zero;
    logic         Sign;
    logic [E-1:0] Exp;
    logic         OutValid;
    logic         OutReady;
    logic         NormSign;
    logic [E-1:0] NormExp;
    logic [N-2:0] NormFrac;
    logic         Overflow;
    logic         Underflow;

    int n_vec = 0;
    int n_err = 0;

    fp_normalizer dut (
        .clock     (clock),
        .reset     (reset),
        .InValid   (InValid),
        .InReady   (InReady),
        .Frac      (Frac),
        .Carry     (Carry),
        .Zero      (Zero),
        .Sign      (Sign),
        .Exp       (Exp),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .NormSign  (NormSign),
        .NormExp   (NormExp),
        .NormFrac  (NormFrac),
        .Overflow  (Overflow),
        .Underflow (Underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // {NormSign, NormExp, NormFrac, Overflow, Underflow}
    function automatic logic [33:0] result();
        return {NormSign, NormExp, NormFrac, Overflow, Underflow};
    endfunction

    // Drives one transfer from IDLE and waits (bounded) for OutValid.
    // lat counts cycles after the transfer cycle T; -1 means no result arrived.
    task automatic send(input logic [N-1:0] f, input logic c, input logic z,
                        input logic s, input logic [E-1:0] e,
                        output int lat, output bit ir_low);
        Frac = f; Carry = c; Zero = z; Sign = s; Exp = e; InValid = 1'b1;
        @(posedge clock); #1;
        InValid = 1'b0; Frac = '0; Carry = 1'b0; Zero = 1'b0; Sign = 1'b0; Exp = '0;
        lat = 1;
        ir_low = 1'b1;
        while (!OutValid && lat < 60) begin
            if (InReady !== 1'b0) ir_low = 1'b0;
            @(posedge clock); #1;
            lat++;
        end
        if (InReady !== 1'b0) ir_low = 1'b0;
        if (!OutValid) lat = -1;
    endtask

    task automatic accept();
        OutReady = 1'b1;
        @(posedge clock); #1;
        OutReady = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_vec++;
        if ({InReady, OutValid} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_handshake: got InReady/OutValid=%b expected 10", {InReady, OutValid});
        end
        n_vec++;
        if (result() !== 34'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h expected 0", result());
        end
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_basic();
        int lat; bit irl;
        send(24'h800000, 1'b0, 1'b0, 1'b0, 8'd127, lat, irl);
        n_vec++;
        if (lat !== 2) begin n_err++; $display("FAIL basic_latency: got %0d expected 2", lat); end
        n_vec++;
        if (result() !== {1'b0, 8'd127, 23'h0, 2'b00}) begin
            n_err++; $display("FAIL basic_result: got %h expected %h", result(), {1'b0, 8'd127, 23'h0, 2'b00});
        end
        accept();
    endtask

    task automatic test_carry();
        int lat; bit irl;
        send(24'h000000, 1'b1, 1'b0, 1'b1, 8'd127, lat, irl);
        n_vec++;
        if (lat !== 2) begin n_err++; $display("FAIL carry_latency: got %0d expected 2", lat); end
        n_vec++;
        if (result() !== {1'b1, 8'd128, 23'h0, 2'b00}) begin
            n_err++; $display("FAIL carry_result: got %h expected %h", result(), {1'b1, 8'd128, 23'h0, 2'b00});
        end
        accept();
    endtask

    task automatic test_long_shift();
        int lat; bit irl;
        send(24'h000100, 1'b0, 1'b0, 1'b0, 8'd127, lat, irl);
        n_vec++;
        if (lat !== 17) begin n_err++; $display("FAIL shift15_latency: got %0d expected 17", lat); end
        n_vec++;
        if (result() !== {1'b0, 8'd112, 23'h0, 2'b00}) begin
            n_err++; $display("FAIL shift15_result: got %h expected %h", result(), {1'b0, 8'd112, 23'h0, 2'b00});
        end
        n_vec++;
        if (irl !== 1'b1) begin n_err++; $display("FAIL shift15_inready: InReady rose while busy, expected 0"); end
        accept();
    endtask

    task automatic test_zero_overflow();
        int lat; bit irl;
        send(24'h5A5A5A, 1'b1, 1'b1, 1'b1, 8'd90, lat, irl);
        n_vec++;
        if (lat !== 1) begin n_err++; $display("FAIL zero_latency: got %0d expected 1", lat); end
        n_vec++;
        if (result() !== 34'h0) begin n_err++; $display("FAIL zero_result: got %h expected 0", result()); end
        accept();
        send(24'h123456, 1'b1, 1'b0, 1'b1, 8'd254, lat, irl);
        n_vec++;
        if (lat !== 1) begin n_err++; $display("FAIL ovf_latency: got %0d expected 1", lat); end
        n_vec++;
        if (result() !== {1'b1, 8'd255, 23'h0, 2'b10}) begin
            n_err++; $display("FAIL ovf_result: got %h expected %h", result(), {1'b1, 8'd255, 23'h0, 2'b10});
        end
        accept();
    endtask

    task automatic test_underflow();
        int lat; bit irl;
        send(24'h000001, 1'b0, 1'b0, 1'b0, 8'd3, lat, irl);
        n_vec++;
        if (lat !== 4) begin n_err++; $display("FAIL unf_latency: got %0d expected 4", lat); end
        n_vec++;
        if (result() !== {1'b0, 8'd0, 23'h000004, 2'b01}) begin
            n_err++; $display("FAIL unf_result: got %h expected %h", result(), {1'b0, 8'd0, 23'h000004, 2'b01});
        end
        accept();
        // Exponent already zero: underflow on the first NORM cycle, no shift.
        send(24'h400000, 1'b0, 1'b0, 1'b1, 8'd0, lat, irl);
        n_vec++;
        if (lat !== 2) begin n_err++; $display("FAIL unf_exp0_latency: got %0d expected 2", lat); end
        n_vec++;
        if (result() !== {1'b1, 8'd0, 23'h400000, 2'b01}) begin
            n_err++; $display("FAIL unf_exp0_result: got %h expected %h", result(), {1'b1, 8'd0, 23'h400000, 2'b01});
        end
        accept();
    endtask

    task automatic test_backpressure();
        int lat; bit irl; bit stable;
        send(24'hC00001, 1'b0, 1'b0, 1'b1, 8'd100, lat, irl);
        stable = 1'b1;
        InValid = 1'b1; Frac = 24'h000001; Exp = 8'd50;
        for (int i = 0; i < 5; i++) begin
            if ({OutValid, InReady} !== 2'b10) stable = 1'b0;
            if (result() !== {1'b1, 8'd100, 23'h400001, 2'b00}) stable = 1'b0;
            @(posedge clock); #1;
        end
        InValid = 1'b0; Frac = '0; Exp = '0;
        n_vec++;
        if (stable !== 1'b1) begin
            n_err++; $display("FAIL bp_hold: got %h valid=%b expected %h held", result(), OutValid, {1'b1, 8'd100, 23'h400001, 2'b00});
        end
        accept();
        n_vec++;
        if ({OutValid, InReady} !== 2'b01) begin
            n_err++; $display("FAIL bp_release: got OutValid/InReady=%b expected 01", {OutValid, InReady});
        end
    endtask

    task automatic test_reset_mid();
        int lat; bit irl;
        Frac = 24'h000100; Exp = 8'd127; Carry = 1'b0; Zero = 1'b0; Sign = 1'b1; InValid = 1'b1;
        @(posedge clock); #1;
        InValid = 1'b0;
        // Now in NORM cycle 1; advance to NORM cycle 8.
        repeat (7) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        n_vec++;
        if ({InReady, OutValid} !== 2'b10) begin
            n_err++; $display("FAIL midreset_handshake: got InReady/OutValid=%b expected 10", {InReady, OutValid});
        end
        n_vec++;
        if (result() !== 34'h0) begin n_err++; $display("FAIL midreset_outputs: got %h expected 0", result()); end
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        send(24'h008000, 1'b0, 1'b0, 1'b0, 8'd130, lat, irl);
        n_vec++;
        if (lat !== 10) begin n_err++; $display("FAIL post_reset_latency: got %0d expected 10", lat); end
        n_vec++;
        if (result() !== {1'b0, 8'd122, 23'h0, 2'b00}) begin
            n_err++; $display("FAIL post_reset_result: got %h expected %h", result(), {1'b0, 8'd122, 23'h0, 2'b00});
        end
        accept();
    endtask

    initial begin
        reset = 1'b1; InValid = 1'b0; OutReady = 1'b0;
        Frac = '0; Carry = 1'b0; Zero = 1'b0; Sign = 1'b0; Exp = '0;
        test_reset();
        test_basic();
        test_carry();
        test_long_shift();
        test_zero_overflow();
        test_underflow();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
